stopwatch_control: RTL and testbench

- Front-panel controller that sequences `stopwatch_counter`.
- Debounces two raw push-buttons (start/stop, lap/reset) and runs a run/pause/lap/clear state machine.
- Drives the counter's enable and clear inputs.
- Holds a display copy of the 8 BCD digits, frozen during a lap split; sits between the board buttons and the counter/7-segment driver.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/button_debounce.sv | 51 +++++
 rtl/stopwatch_control.sv | 84 ++++++++
 tb/tb_stopwatch_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: FSM state encoding and the BCD digit packing that is
// also used by the display driver.
package stopwatch_pkg;

  localparam int STATE_W    = 3;
  localparam int BCD_DIGITS = 8;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    LAP     = 3'd2,
    PAUSED  = 3'd3,
    CLEAR   = 3'd4
  } swState_e;

  // Most significant nibble first, matching liveBcdIn / displayBcdOut.
  typedef struct packed {
    logic [3:0] hourOne;
    logic [3:0] minuteTen;
    logic [3:0] minuteOne;
    logic [3:0] secondTen;
    logic [3:0] secondOne;
    logic [3:0] milliHundred;
    logic [3:0] milliTen;
    logic [3:0] milliOne;
  } bcdDigits_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw button, accepts a level only after it has been stable for
// DEBOUNCE_CYCLES clocks, and emits a one-cycle registered pulse on press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clkIn,
  input  logic rstNIn,
  input  logic btnIn,
  output logic levelOut,
  output logic pressOut
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stableD;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stableD  <= 1'b0;
      cnt      <= '0;
      pressOut <= 1'b0;
    end else begin
      sync1    <= btnIn;
      sync2    <= sync1;
      stableD  <= stable;
      pressOut <= stable & ~stableD;
      // Any cycle where the synced level agrees with stable restarts the count.
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign levelOut = stable;

endmodule

// File: rtl/stopwatch_control.sv
// Front-panel controller: debounced start/stop and lap/reset buttons drive a
// run/pause/lap/clear FSM that sequences the counter and latches the display.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clkIn,
  input  logic                rstNIn,
  input  logic                startStopBtnIn,
  input  logic                lapResetBtnIn,
  input  logic [BCD_W-1:0]    liveBcdIn,
  output logic                enCounterOut,
  output logic                clrCounterOut,
  output logic                lapHoldOut,
  output logic [BCD_W-1:0]    displayBcdOut,
  output logic [STATE_W-1:0]  stateOut
);

  swState_e state;
  swState_e nextState;
  logic     startStopPress;
  logic     lapResetPress;
  logic     unusedStartStopLevel;
  logic     unusedLapResetLevel;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStartStop (
    .clkIn    (clkIn),
    .rstNIn   (rstNIn),
    .btnIn    (startStopBtnIn),
    .levelOut (unusedStartStopLevel),
    .pressOut (startStopPress)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLapReset (
    .clkIn    (clkIn),
    .rstNIn   (rstNIn),
    .btnIn    (lapResetBtnIn),
    .levelOut (unusedLapResetLevel),
    .pressOut (lapResetPress)
  );

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // startStop is tested first in every state so it wins a same-cycle tie.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startStopPress) nextState = RUNNING;
      RUNNING: if (startStopPress) nextState = PAUSED;
               else if (lapResetPress) nextState = LAP;
      LAP:     if (startStopPress) nextState = PAUSED;
               else if (lapResetPress) nextState = RUNNING;
      PAUSED:  if (startStopPress) nextState = RUNNING;
               else if (lapResetPress) nextState = CLEAR;
      CLEAR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    enCounterOut  = (state == RUNNING) || (state == LAP);
    clrCounterOut = (state == CLEAR);
    lapHoldOut    = (state == LAP);
    stateOut      = state;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      displayBcdOut <= '0;
    end else if (state == CLEAR) begin
      displayBcdOut <= '0;
    end else if (state != LAP) begin
      displayBcdOut <= liveBcdIn;
    end
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with a short debounce window.
module tb_stopwatch_control;
  import stopwatch_pkg::*;

  logic        clkIn;
  logic        rstNIn;
  logic        startStopBtnIn;
  logic        lapResetBtnIn;
  logic [31:0] liveBcdIn;
  logic        enCounterOut;
  logic        clrCounterOut;
  logic        lapHoldOut;
  logic [31:0] displayBcdOut;
  logic [2:0]  stateOut;

  int checks   = 0;
  int failures = 0;

  stopwatch_control #(.DEBOUNCE_CYCLES(4)) dut (
    .clkIn          (clkIn),
    .rstNIn         (rstNIn),
    .startStopBtnIn (startStopBtnIn),
    .lapResetBtnIn  (lapResetBtnIn),
    .liveBcdIn      (liveBcdIn),
    .enCounterOut   (enCounterOut),
    .clrCounterOut  (clrCounterOut),
    .lapHoldOut     (lapHoldOut),
    .displayBcdOut  (displayBcdOut),
    .stateOut       (stateOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  // Raise the chosen buttons on a falling edge; returns on the falling edge
  // right after the FSM has taken the debounced press (2 + 4 + 1 + 1 edges).
  task automatic pressRaise(input logic ss, input logic lr);
    @(negedge clkIn);
    if (ss) startStopBtnIn = 1'b1;
    if (lr) lapResetBtnIn = 1'b1;
    waitNeg(8);
  endtask

  task automatic releaseAll();
    startStopBtnIn = 1'b0;
    lapResetBtnIn  = 1'b0;
    waitNeg(10);
  endtask

  task automatic test_reset();
    rstNIn = 1'b0;
    startStopBtnIn = 1'b0;
    lapResetBtnIn = 1'b0;
    liveBcdIn = 32'h1234_5678;
    waitNeg(3);
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", stateOut); end
    checks++; if (enCounterOut !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", enCounterOut); end
    checks++; if (clrCounterOut !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", clrCounterOut); end
    checks++; if (lapHoldOut !== 1'b0) begin failures++; $display("FAIL reset_lap got=%b exp=0", lapHoldOut); end
    checks++; if (displayBcdOut !== 32'h0) begin failures++; $display("FAIL reset_disp got=%h exp=00000000", displayBcdOut); end
    liveBcdIn = 32'h0;
    rstNIn = 1'b1;
    waitNeg(3);
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", stateOut); end
    checks++; if (enCounterOut !== 1'b0) begin failures++; $display("FAIL idle_en got=%b exp=0", enCounterOut); end
    checks++; if (displayBcdOut !== 32'h0) begin failures++; $display("FAIL idle_disp got=%h exp=00000000", displayBcdOut); end
    liveBcdIn = 32'h0000_0042;
    @(negedge clkIn);
    checks++; if (displayBcdOut !== 32'h0000_0042) begin failures++; $display("FAIL idle_track got=%h exp=00000042", displayBcdOut); end
    liveBcdIn = 32'h0;
    @(negedge clkIn);
  endtask

  task automatic test_bounce();
    int pulses;
    int pulseAt;
    pulses = 0;
    pulseAt = -1;
    for (int i = 0; i < 20; i++) begin
      startStopBtnIn = ((i / 2) % 2 == 0);
      @(negedge clkIn);
      if (dut.uStartStop.pressOut === 1'b1) pulses++;
    end
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL bounce_ignored got=%0d exp=0", stateOut); end
    startStopBtnIn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clkIn);
      if (dut.uStartStop.pressOut === 1'b1) begin pulses++; pulseAt = k; end
      if (k == 7) begin
        checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL bounce_pre_state got=%0d exp=0", stateOut); end
      end
      if (k == 8) begin
        checks++; if (stateOut !== 3'd1) begin failures++; $display("FAIL bounce_state got=%0d exp=1", stateOut); end
        checks++; if (enCounterOut !== 1'b1) begin failures++; $display("FAIL bounce_en got=%b exp=1", enCounterOut); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", pulses); end
    checks++; if (pulseAt != 7) begin failures++; $display("FAIL bounce_latency got=%0d exp=7", pulseAt); end
    releaseAll();
    checks++; if (stateOut !== 3'd1) begin failures++; $display("FAIL release_nopulse got=%0d exp=1", stateOut); end
  endtask

  task automatic test_lap_freeze();
    bcdDigits_t d;
    @(negedge clkIn);
    liveBcdIn = 32'h0001_2345;
    pressRaise(1'b0, 1'b1);
    checks++; if (stateOut !== 3'd2) begin failures++; $display("FAIL lap_state got=%0d exp=2", stateOut); end
    checks++; if (lapHoldOut !== 1'b1) begin failures++; $display("FAIL lap_hold got=%b exp=1", lapHoldOut); end
    checks++; if (enCounterOut !== 1'b1) begin failures++; $display("FAIL lap_en got=%b exp=1", enCounterOut); end
    checks++; if (displayBcdOut !== 32'h0001_2345) begin failures++; $display("FAIL lap_disp got=%h exp=00012345", displayBcdOut); end
    d = bcdDigits_t'(displayBcdOut);
    checks++; if ({d.secondTen, d.milliOne} !== 8'h15) begin failures++; $display("FAIL lap_digits got=%h exp=15", {d.secondTen, d.milliOne}); end
    for (int i = 0; i < 4; i++) begin
      liveBcdIn = 32'h0001_2346 + 32'(i);
      @(negedge clkIn);
      checks++; if (displayBcdOut !== 32'h0001_2345) begin failures++; $display("FAIL lap_frozen%0d got=%h exp=00012345", i, displayBcdOut); end
    end
    releaseAll();
    checks++; if (lapHoldOut !== 1'b1) begin failures++; $display("FAIL lap_hold_rel got=%b exp=1", lapHoldOut); end
    pressRaise(1'b0, 1'b1);
    checks++; if (stateOut !== 3'd1) begin failures++; $display("FAIL unlap_state got=%0d exp=1", stateOut); end
    checks++; if (lapHoldOut !== 1'b0) begin failures++; $display("FAIL unlap_hold got=%b exp=0", lapHoldOut); end
    checks++; if (enCounterOut !== 1'b1) begin failures++; $display("FAIL unlap_en got=%b exp=1", enCounterOut); end
    liveBcdIn = 32'h0001_2400;
    @(negedge clkIn);
    checks++; if (displayBcdOut !== 32'h0001_2400) begin failures++; $display("FAIL unlap_track got=%h exp=00012400", displayBcdOut); end
    releaseAll();
  endtask

  task automatic test_clear();
    pressRaise(1'b1, 1'b0);
    checks++; if (stateOut !== 3'd3) begin failures++; $display("FAIL pause_state got=%0d exp=3", stateOut); end
    checks++; if (enCounterOut !== 1'b0) begin failures++; $display("FAIL pause_en got=%b exp=0", enCounterOut); end
    releaseAll();
    liveBcdIn = 32'h0000_0777;
    pressRaise(1'b0, 1'b1);
    checks++; if (stateOut !== 3'd4) begin failures++; $display("FAIL clear_state got=%0d exp=4", stateOut); end
    checks++; if (clrCounterOut !== 1'b1) begin failures++; $display("FAIL clear_pulse got=%b exp=1", clrCounterOut); end
    @(negedge clkIn);
    checks++; if (clrCounterOut !== 1'b0) begin failures++; $display("FAIL clear_once got=%b exp=0", clrCounterOut); end
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL clear_idle got=%0d exp=0", stateOut); end
    checks++; if (displayBcdOut !== 32'h0) begin failures++; $display("FAIL clear_disp got=%h exp=00000000", displayBcdOut); end
    @(negedge clkIn);
    checks++; if (displayBcdOut !== 32'h0000_0777) begin failures++; $display("FAIL clear_retrack got=%h exp=00000777", displayBcdOut); end
    releaseAll();
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL idle_lap_ignored got=%0d exp=0", stateOut); end
  endtask

  task automatic test_back_to_back();
    pressRaise(1'b1, 1'b0);
    checks++; if (stateOut !== 3'd1) begin failures++; $display("FAIL b2b_run got=%0d exp=1", stateOut); end
    releaseAll();
    pressRaise(1'b1, 1'b1);
    checks++; if (stateOut !== 3'd3) begin failures++; $display("FAIL both_state got=%0d exp=3", stateOut); end
    checks++; if (lapHoldOut !== 1'b0) begin failures++; $display("FAIL both_hold got=%b exp=0", lapHoldOut); end
    @(negedge clkIn);
    checks++; if (stateOut !== 3'd3) begin failures++; $display("FAIL both_stay got=%0d exp=3", stateOut); end
    releaseAll();
  endtask

  task automatic test_async_reset();
    pressRaise(1'b1, 1'b0);
    releaseAll();
    liveBcdIn = 32'h0005_9999;
    pressRaise(1'b0, 1'b1);
    checks++; if (stateOut !== 3'd2) begin failures++; $display("FAIL arst_pre_lap got=%0d exp=2", stateOut); end
    @(posedge clkIn);
    #2;
    rstNIn = 1'b0;
    #1;
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", stateOut); end
    checks++; if (enCounterOut !== 1'b0) begin failures++; $display("FAIL arst_en got=%b exp=0", enCounterOut); end
    checks++; if (lapHoldOut !== 1'b0) begin failures++; $display("FAIL arst_hold got=%b exp=0", lapHoldOut); end
    checks++; if (displayBcdOut !== 32'h0) begin failures++; $display("FAIL arst_disp got=%h exp=00000000", displayBcdOut); end
    lapResetBtnIn = 1'b0;
    waitNeg(2);
    rstNIn = 1'b1;
    waitNeg(2);
    pressRaise(1'b0, 1'b1);
    waitNeg(2);
    checks++; if (stateOut !== 3'd0) begin failures++; $display("FAIL arst_lap_idle got=%0d exp=0", stateOut); end
    checks++; if (enCounterOut !== 1'b0) begin failures++; $display("FAIL arst_lap_en got=%b exp=0", enCounterOut); end
    releaseAll();
  endtask

  initial begin
    rstNIn = 1'b0;
    startStopBtnIn = 1'b0;
    lapResetBtnIn = 1'b0;
    liveBcdIn = 32'h0;
    test_reset();
    test_bounce();
    test_lap_freeze();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
